fft_sdf_stage: RTL and testbench
================================

# fft_sdf_stage

Parametrised radix-2 decimation-in-frequency single-path delay-feedback (SDF) stage with a complex twiddle multiplier, an inverse-transform mode, a self-draining circular buffer and output saturation. It replaces the fixed-size, fixed-width per-stage modules. An N-point streaming FFT is built by chaining log2(N) instances with DEPTH = N/2, N/4, …, 1, each widening the data by one bit. The twiddle ROM sits outside the block and is shared or replicated per instance.

## Interface
- IN_W, 8: input component width, signed two's complement.
- OUT_W, IN_W+1: output component width; must be ≥ IN_W+1.
- TW_W, 10: twiddle component width, signed; 1.0 = 2^(TW_W-2).
- DEPTH, 16: half block length; power of two, ≥ 1; also the buffer depth.
- TW_STRIDE, 1: twiddle address multiplier (N/(2·DEPTH)).
- AW, clog2 of max(DEPTH·TW_STRIDE, 2): twiddle address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  input sample strobe.
- inverse_i  in  1  inverse mode; sampled with the first sample of each block.
- data_in_r, data_in_i  in  IN_W each  input sample.
- tw_addr  out  AW  twiddle ROM address.
- tw_r, tw_i  in  TW_W each  ROM data for tw_addr; sampled one cycle after tw_addr is issued (synchronous ROM).
- valid_o  out  1  output strobe.
- data_out_r, data_out_i  out  OUT_W each  output sample.
- ovf_o  out  1  sticky saturation flag.

## Operation
- **Block framing.** A block is 2·DEPTH accepted samples. `cnt` runs mod 2·DEPTH and advances only on valid_i.
  - Phase A: cnt < DEPTH.
  - Phase B: cnt ≥ DEPTH.
- **Buffer.** Circular buffer of DEPTH entries, OUT_W-bit complex.
  - Write and read pointers are separate.
  - `diff_cnt` (0..DEPTH) counts the pending differences at the head of the buffer.
- **Phase A input.** The sample is sign-extended and pushed. No output is produced.
- **Phase B input.** Pop head h; emit sum h+x with twiddle 1; push difference h−x.
- **End of block.** On the last sample, diff_cnt is set to DEPTH.
- **Drain.** Every cycle with diff_cnt > 0 and no phase-B input, pop one difference.
  - The k-th difference (k = 0..DEPTH-1) is emitted multiplied by twiddle address k·TW_STRIDE.
  - Drain runs whether valid_i is high or low.
  - Drain may overlap the next block's phase A: same-cycle push and pop is allowed, including when the buffer is full (read-before-write).
- **Ordering guarantee.** With contiguous blocks, drain completes before phase B, so at most one output event occurs per cycle.
- **Input contract.** Samples within a block need not be contiguous. Gaps of any length are allowed.
- **Inverse mode.** inverse_i is latched when a block's first sample is accepted. That block's differences use conj(w), i.e. tw_i is negated.
- **Arithmetic.**
  - Butterfly is full precision in OUT_W.
  - Complex product (a+jb)(c+jd) = (ac−bd) + j(ad+bc).
  - Rounding: add 2^(TW_W-3), then arithmetic shift right by TW_W-2.
  - Each component is saturated to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
  - Any saturation sets ovf_o.
- **ovf_o clearing.** ovf_o clears only on reset.
- **Reset.** Asserting reset at any time discards pending data and restarts framing at cnt = 0.

## Timing
- **Pipeline.** Two stages.
  - E: event cycle (phase-B input or drain pop); issues tw_addr.
  - M: multiply, round, saturate; registers the outputs.
- **Latency.** valid_o rises exactly 2 cycles after the event cycle. Sums have latency 2 from their input.
- **Difference timing.** The first difference of a block is emitted 3 cycles after the block's last input.
- **Output rate.** At most one output per cycle. A continuous input stream yields a continuous output stream after the first DEPTH+2 cycles.
- **Addressing.** tw_addr is 0 on sum events and during idle.
- **Reset values.** All outputs are 0: valid_o, data_out_r, data_out_i, tw_addr and ovf_o. All of cnt, pointers, diff_cnt and the inverse latch are also 0.

## Test plan
- **Forward, DEPTH=2, IN_W=8, TW_W=10.**
  - Stimulus: real block 1,2,3,4; ROM addr0=(256,0), addr1=(0,−256).
  - Required outputs in order: (4,0), (6,0), (−2,0), (0,2).
  - valid_o at input cycles 2+2, 3+2, then 6, 7.
- **Inverse.** Same block with inverse_i=1 → (4,0), (6,0), (−2,0), (0,−2).
- **Saturation.**
  - Stimulus: DEPTH=2; samples (0,0), (127,127), (0,0), (−128,−128); ROM addr1=(181,−181).
  - Fourth output = (255,0); ovf_o rises with it and stays high.
- **Back-to-back and gaps.**
  - DEPTH=1: contiguous stream 5,3,7,1 → outputs 8, 2, 8, 6 with valid_o high for 4 consecutive cycles.
  - Repeat with a 3-cycle gap inside each block: identical values.
- **Drain overlap.** DEPTH=4: the next block starts the cycle after the previous block ends. Differences and the new block's sums appear in order, with no lost or duplicated outputs.
- **Reset mid-block.** rst_n low after 3 samples → all outputs 0 immediately; a fresh block after release produces correct results.

Source files
------------

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage: butterfly, circular buffer,
// twiddle rotation of drained differences, rounding, saturation and inverse mode.
module fft_sdf_stage #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = IN_W + 1,
  parameter int TW_W      = 10,
  parameter int DEPTH     = 16,
  parameter int TW_STRIDE = 1,
  parameter int AW        = $clog2((DEPTH * TW_STRIDE > 2) ? DEPTH * TW_STRIDE : 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             inverse_i,
  input  logic [IN_W-1:0]  data_in_r,
  input  logic [IN_W-1:0]  data_in_i,
  output logic [AW-1:0]    tw_addr,
  input  logic [TW_W-1:0]  tw_r,
  input  logic [TW_W-1:0]  tw_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_out_r,
  output logic [OUT_W-1:0] data_out_i,
  output logic             ovf_o
);

  localparam int CW    = $clog2(2 * DEPTH);
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUF_N = 2 ** PTRW;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int PW    = OUT_W + TW_W + 3;
  localparam logic [CW-1:0]          CNT_LAST  = CW'(2 * DEPTH - 1);
  localparam logic [PTRW-1:0]        PTR_LAST  = PTRW'(DEPTH - 1);
  localparam logic [DW-1:0]          DIFF_FULL = DW'(DEPTH);
  localparam logic signed [PW-1:0]   RND       = PW'(2 ** (TW_W - 3));
  localparam logic signed [PW-1:0]   SAT_MAX   = PW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PW-1:0]   SAT_MIN   = ~SAT_MAX;

  // Clamp to the output range; MSB of the result flags a clip.
  function automatic logic [OUT_W:0] sat_f(input logic signed [PW-1:0] v);
    logic [OUT_W:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[OUT_W-1:0]};
    else                  r = {1'b0, v[OUT_W-1:0]};
    return r;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   diff_cnt_q, diff_cnt_d;
  logic            inv_blk_q, inv_blk_d, inv_drn_q, inv_drn_d;
  logic [OUT_W-1:0] buf_r_q [BUF_N];
  logic [OUT_W-1:0] buf_i_q [BUF_N];
  logic            m_vld_q, m_vld_d, m_rot_q, m_rot_d, m_inv_q, m_inv_d;
  logic signed [OUT_W-1:0] m_a_r_q, m_a_r_d, m_a_i_q, m_a_i_d;
  logic            valid_q, valid_d, ovf_q, ovf_d;
  logic [OUT_W-1:0] out_r_q, out_r_d, out_i_q, out_i_d;

  logic in_b_s, drain_s, pop_s, last_s;
  logic signed [OUT_W-1:0] x_r_s, x_i_s, h_r_s, h_i_s, push_r_s, push_i_s;
  logic [31:0] k_s;
  logic [AW-1:0] tw_addr_s;
  logic signed [PW-1:0] ar_s, ai_s, tr_s, ti_s, pr_s, pi_s;
  logic [OUT_W:0] sat_r_s, sat_i_s;

  // Event stage: framing, buffer pointers, butterfly and twiddle addressing.
  always_comb begin
    in_b_s   = valid_i & cnt_q[CW-1];
    drain_s  = (diff_cnt_q != {DW{1'b0}}) & ~in_b_s;
    pop_s    = in_b_s | drain_s;
    last_s   = in_b_s & (cnt_q == CNT_LAST);
    x_r_s    = OUT_W'($signed(data_in_r));
    x_i_s    = OUT_W'($signed(data_in_i));
    h_r_s    = buf_r_q[rd_ptr_q];
    h_i_s    = buf_i_q[rd_ptr_q];
    push_r_s = x_r_s;
    push_i_s = x_i_s;
    m_a_r_d  = h_r_s;
    m_a_i_d  = h_i_s;
    if (in_b_s) begin
      push_r_s = h_r_s - x_r_s;
      push_i_s = h_i_s - x_i_s;
      m_a_r_d  = h_r_s + x_r_s;
      m_a_i_d  = h_i_s + x_i_s;
    end else begin
      push_r_s = x_r_s;
      push_i_s = x_i_s;
    end
    m_vld_d = pop_s;
    m_rot_d = drain_s;
    m_inv_d = inv_drn_q;

    cnt_d    = valid_i ? cnt_q + 1'b1 : cnt_q;
    wr_ptr_d = wr_ptr_q;
    if (valid_i) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTRW{1'b0}} : wr_ptr_q + 1'b1;
    else         wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_s) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTRW{1'b0}} : rd_ptr_q + 1'b1;
    else       rd_ptr_d = rd_ptr_q;

    if (last_s)       diff_cnt_d = DIFF_FULL;
    else if (drain_s) diff_cnt_d = diff_cnt_q - 1'b1;
    else              diff_cnt_d = diff_cnt_q;

    // Drain keeps its own copy so the next block may latch a new mode mid-drain.
    inv_blk_d = (valid_i && cnt_q == {CW{1'b0}}) ? inverse_i : inv_blk_q;
    inv_drn_d = last_s ? inv_blk_q : inv_drn_q;

    k_s       = 32'(DEPTH) - 32'(diff_cnt_q);
    tw_addr_s = drain_s ? AW'(k_s * 32'(TW_STRIDE)) : {AW{1'b0}};
  end

  // Multiply stage: complex rotation, rounding, saturation and output hold.
  always_comb begin
    ar_s    = PW'(m_a_r_q);
    ai_s    = PW'(m_a_i_q);
    tr_s    = PW'($signed(tw_r));
    ti_s    = m_inv_q ? -PW'($signed(tw_i)) : PW'($signed(tw_i));
    pr_s    = (ar_s * tr_s - ai_s * ti_s + RND) >>> (TW_W - 2);
    pi_s    = (ar_s * ti_s + ai_s * tr_s + RND) >>> (TW_W - 2);
    sat_r_s = sat_f(pr_s);
    sat_i_s = sat_f(pi_s);
    valid_d = m_vld_q;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    ovf_d   = ovf_q;
    if (m_vld_q && m_rot_q) begin
      out_r_d = sat_r_s[OUT_W-1:0];
      out_i_d = sat_i_s[OUT_W-1:0];
      ovf_d   = ovf_q | sat_r_s[OUT_W] | sat_i_s[OUT_W];
    end else if (m_vld_q) begin
      out_r_d = m_a_r_q;
      out_i_d = m_a_i_q;
    end else begin
      out_r_d = out_r_q;
      out_i_d = out_i_q;
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {CW{1'b0}};
      wr_ptr_q   <= {PTRW{1'b0}};
      rd_ptr_q   <= {PTRW{1'b0}};
      diff_cnt_q <= {DW{1'b0}};
      inv_blk_q  <= 1'b0;
      inv_drn_q  <= 1'b0;
      m_vld_q    <= 1'b0;
      m_rot_q    <= 1'b0;
      m_inv_q    <= 1'b0;
      m_a_r_q    <= {OUT_W{1'b0}};
      m_a_i_q    <= {OUT_W{1'b0}};
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      out_r_q    <= {OUT_W{1'b0}};
      out_i_q    <= {OUT_W{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      diff_cnt_q <= diff_cnt_d;
      inv_blk_q  <= inv_blk_d;
      inv_drn_q  <= inv_drn_d;
      m_vld_q    <= m_vld_d;
      m_rot_q    <= m_rot_d;
      m_inv_q    <= m_inv_d;
      m_a_r_q    <= m_a_r_d;
      m_a_i_q    <= m_a_i_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      out_r_q    <= out_r_d;
      out_i_q    <= out_i_d;
    end
  end

  // Delay-line storage; the read above sees the old entry on a same-slot write.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      buf_r_q[wr_ptr_q] <= push_r_s;
      buf_i_q[wr_ptr_q] <= push_i_s;
    end
  end

  assign tw_addr    = tw_addr_s;
  assign valid_o    = valid_q;
  assign data_out_r = out_r_q;
  assign data_out_i = out_i_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Scoreboard bench for fft_sdf_stage: three instances (DEPTH 1, 2, 4) checked
// against a block-level butterfly/twiddle reference model.
module tb_fft_sdf_stage;

  typedef struct {
    int cyc;
    int r;
    int i;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       vld_a [3];
  logic       inv_a [3];
  logic [7:0] dr_a  [3];
  logic [7:0] di_a  [3];
  wire        vo_a  [3];
  wire  [8:0] dor_a [3];
  wire  [8:0] doi_a [3];
  wire        ovf_a [3];
  wire  [1:0] ta_a  [3];

  logic [9:0] rom_r [4];
  logic [9:0] rom_i [4];
  int blk_r [8];
  int blk_i [8];
  exp_t exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D   = 1 << g;
    localparam int AWG = $clog2((D > 2) ? D : 2);
    logic [AWG-1:0] ta;
    logic [9:0] twr_q = 10'd0;
    logic [9:0] twi_q = 10'd0;
    bit ovf_m = 1'b0;
    exp_t e;

    fft_sdf_stage #(.IN_W(8), .OUT_W(9), .TW_W(10), .DEPTH(D), .TW_STRIDE(1), .AW(AWG)) u_dut (
      .clk(clk), .rst_n(rst_n), .valid_i(vld_a[g]), .inverse_i(inv_a[g]),
      .data_in_r(dr_a[g]), .data_in_i(di_a[g]), .tw_addr(ta),
      .tw_r(twr_q), .tw_i(twi_q), .valid_o(vo_a[g]),
      .data_out_r(dor_a[g]), .data_out_i(doi_a[g]), .ovf_o(ovf_a[g])
    );

    assign ta_a[g] = 2'(ta);

    always @(posedge clk) begin
      twr_q <= rom_r[ta_a[g]];
      twi_q <= rom_i[ta_a[g]];
    end

    always @(negedge clk) begin
      if (!rst_n) ovf_m = 1'b0;
      if (rst_n && vo_a[g] === 1'b1) begin
        n_tests++;
        if (exp_q[g].size() == 0) begin
          n_fail++;
          $display("FAIL d%0d_unexpected got (%0d,%0d) at cycle %0d, expected no output",
                   D, $signed(dor_a[g]), $signed(doi_a[g]), cyc);
        end else begin
          e = exp_q[g].pop_front();
          ovf_m = ovf_m | e.sat;
          if (int'($signed(dor_a[g])) != e.r || int'($signed(doi_a[g])) != e.i ||
              cyc != e.cyc || ovf_a[g] !== ovf_m) begin
            n_fail++;
            $display("FAIL d%0d_out got (%0d,%0d) cyc %0d ovf %0b, expected (%0d,%0d) cyc %0d ovf %0b",
                     D, $signed(dor_a[g]), $signed(doi_a[g]), cyc, ovf_a[g],
                     e.r, e.i, e.cyc, ovf_m);
          end
        end
      end
    end
  end

  function automatic int clip9(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  task automatic push_exp(input int g, input int c, input int r, input int i, input bit s);
    exp_t e;
    e.cyc = c;
    e.r   = r;
    e.i   = i;
    e.sat = s;
    exp_q[g].push_back(e);
  endtask

  task automatic idle(input int g, input int n);
    repeat (n) begin
      vld_a[g] = 1'b0;
      dr_a[g]  = 8'($urandom);
      di_a[g]  = 8'($urandom);
      inv_a[g] = 1'($urandom);
      @(posedge clk); #2;
    end
  endtask

  task automatic set_rom(input int k, input int r, input int i);
    rom_r[k] = 10'(r);
    rom_i[k] = 10'(i);
  endtask

  // One block of 2*D samples from blk_r/blk_i; expectations follow the
  // DIF butterfly: sums x[j]+x[j+D] at +2, rotated differences from last+3.
  task automatic run_block(input int g, input bit inv, input int gap_lo, input int gap_hi);
    int d, c_last, xr, xi, wr, wi, pr, pi;
    d = 1 << g;
    c_last = 0;
    for (int n = 0; n < 2 * d; n++) begin
      if (n > 0) idle(g, $urandom_range(gap_hi, gap_lo));
      vld_a[g] = 1'b1;
      dr_a[g]  = 8'(blk_r[n]);
      di_a[g]  = 8'(blk_i[n]);
      inv_a[g] = (n == 0) ? inv : 1'($urandom);
      if (n >= d) push_exp(g, cyc + 2, blk_r[n-d] + blk_r[n], blk_i[n-d] + blk_i[n], 1'b0);
      c_last = cyc;
      @(posedge clk); #2;
    end
    vld_a[g] = 1'b0;
    for (int k = 0; k < d; k++) begin
      xr = blk_r[k] - blk_r[k+d];
      xi = blk_i[k] - blk_i[k+d];
      wr = int'($signed(rom_r[k]));
      wi = int'($signed(rom_i[k]));
      if (inv) wi = -wi;
      pr = (xr * wr - xi * wi + 128) >>> 8;
      pi = (xr * wi + xi * wr + 128) >>> 8;
      push_exp(g, c_last + 3 + k, clip9(pr), clip9(pi), (clip9(pr) != pr) || (clip9(pi) != pi));
    end
  endtask

  task automatic rand_blk(input int d);
    for (int n = 0; n < 2 * d; n++) begin
      blk_r[n] = int'($urandom_range(255, 0)) - 128;
      blk_i[n] = int'($urandom_range(255, 0)) - 128;
    end
  endtask

  task automatic set_blk4(input int r0, input int i0, input int r1, input int i1,
                          input int r2, input int i2, input int r3, input int i3);
    blk_r[0] = r0; blk_i[0] = i0; blk_r[1] = r1; blk_i[1] = i1;
    blk_r[2] = r2; blk_i[2] = i2; blk_r[3] = r3; blk_i[3] = i3;
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (vo_a[g] !== 1'b0 || dor_a[g] !== 9'd0 || doi_a[g] !== 9'd0 ||
          ovf_a[g] !== 1'b0 || ta_a[g] !== 2'd0) begin
        n_fail++;
        $display("FAIL %s_d%0d got valid %0b data (%0d,%0d) ovf %0b addr %0d, expected all 0",
                 tag, 1 << g, vo_a[g], dor_a[g], doi_a[g], ovf_a[g], ta_a[g]);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      vld_a[g] = 1'b0; inv_a[g] = 1'b0; dr_a[g] = 8'd0; di_a[g] = 8'd0;
    end
    for (int k = 0; k < 4; k++) set_rom(k, 0, 0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // DEPTH=2 forward, inverse and saturation
    set_rom(0, 256, 0);
    set_rom(1, 0, -256);
    set_blk4(1, 0, 2, 0, 3, 0, 4, 0);
    run_block(1, 1'b0, 0, 0);
    idle(1, 6);
    run_block(1, 1'b1, 0, 0);
    idle(1, 6);
    set_rom(1, 181, -181);
    set_blk4(0, 0, 127, 127, 0, 0, -128, -128);
    run_block(1, 1'b0, 0, 0);
    idle(1, 6);
    n_tests++;
    if (ovf_a[1] !== 1'b1 || g_dut[1].ovf_m !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold got %0b, expected 1", ovf_a[1]);
    end

    // Reset in the middle of a block
    set_rom(1, 0, -256);
    set_blk4(1, 0, 2, 0, 3, 0, 4, 0);
    for (int n = 0; n < 3; n++) begin
      vld_a[1] = 1'b1; dr_a[1] = 8'(blk_r[n]); di_a[1] = 8'(blk_i[n]); inv_a[1] = 1'b0;
      @(posedge clk); #2;
    end
    vld_a[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    for (int g = 0; g < 3; g++) exp_q[g].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    run_block(1, 1'b0, 0, 0);
    idle(1, 6);

    // DEPTH=1 back-to-back, then with a 3-cycle gap inside each block
    set_rom(0, 256, 0);
    for (int pass = 0; pass < 2; pass++) begin
      blk_r[0] = 5; blk_i[0] = 0; blk_r[1] = 3; blk_i[1] = 0;
      run_block(0, 1'b0, 3 * pass, 3 * pass);
      blk_r[0] = 7; blk_i[0] = 0; blk_r[1] = 1; blk_i[1] = 0;
      run_block(0, 1'b0, 3 * pass, 3 * pass);
      idle(0, 5);
    end

    // DEPTH=4 drain overlapping the next block, then randomized traffic
    for (int k = 0; k < 4; k++) begin
      rom_r[k] = 10'($urandom_range(1023, 0));
      rom_i[k] = 10'($urandom_range(1023, 0));
    end
    for (int b = 0; b < 3; b++) begin
      rand_blk(4);
      run_block(2, 1'($urandom), 0, 0);
    end
    idle(2, 8);
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 16; b++) begin
        rand_blk(1 << g);
        run_block(g, 1'($urandom), 0, ($urandom_range(1, 0) == 1) ? 2 : 0);
        if ($urandom_range(2, 0) == 0) idle(g, $urandom_range(3, 1));
      end
      idle(g, 10);
    end

    idle(0, 10);
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (exp_q[g].size() != 0) begin
        n_fail++;
        $display("FAIL d%0d_drained got %0d outputs still pending, expected 0", 1 << g, exp_q[g].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
